// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared FSM state encoding and instruction geometry for ifetch_seq
package ifetch_pkg;

    localparam int BYTES_PER_INSTR = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_READ  = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_RESP  = 3'd3;
    localparam state_t S_DRAIN = 3'd4;

endpackage

// File: rtl/ifetch_seq.sv
// rtl/ifetch_seq.sv - byte-serial instruction fetch sequencer; optional IFETCH_MISALIGN_CHK_EN
module ifetch_seq
    import ifetch_pkg::*;
#(
    parameter int WAD        = 17,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] pcF,
    input  logic                  flush_i,
    input  logic                  accept_i,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic                  valid_o,
    output logic                  stall_o,
    output logic [WAD-1:0]        mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [7:0]            mem_rdata_i,
    input  logic                  mem_rvalid_i
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam int KW = $clog2(BYTES_PER_INSTR);

    state_t                state_q;
    state_t                state_d;
    logic [WAD-1:0]        pc_q;
    logic [KW-1:0]         k_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  start_ok;
    logic                  new_fetch;
    logic                  beat_take;
    logic                  last_byte;
    logic                  unused_pc_hi;

    // Only the low WAD bits of the pc address the memory.
    assign unused_pc_hi = ^pcF[DATA_WIDTH-1:WAD];

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (pcF[1:0] != 2'b00);
    assign start_ok   = req_i && !misaligned;
    assign misalign_o = req_i && misaligned &&
                        ((state_q == S_IDLE) || ((state_q == S_RESP) && accept_i));
`else
    assign start_ok   = req_i;
`endif

    assign last_byte = (k_q == KW'(BYTES_PER_INSTR - 1));
    assign new_fetch = !flush_i && start_ok &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && accept_i));
    assign beat_take = (state_q == S_WAIT) && mem_rvalid_i && !flush_i;

    // Next-state logic; flush always wins over accept and returned data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!flush_i && start_ok) state_d = S_READ;
            end
            S_READ: begin
                state_d = flush_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // A beat arriving together with the flush is the one we would
                // otherwise drain, so it is dropped here and DRAIN is skipped.
                if (flush_i)           state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                else if (mem_rvalid_i) state_d = last_byte ? S_RESP : S_READ;
            end
            S_RESP: begin
                if (flush_i)       state_d = S_IDLE;
                else if (accept_i) state_d = start_ok ? S_READ : S_IDLE;
            end
            S_DRAIN: begin
                // The outstanding beat retires the drain even under a repeated
                // flush; waiting for another beat would never terminate.
                if (mem_rvalid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Latch the fetch pc, step the byte counter and assemble the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            k_q     <= '0;
            instr_q <= '0;
        end else if (new_fetch) begin
            pc_q <= pcF[WAD-1:0];
            k_q  <= '0;
        end else if (beat_take) begin
            instr_q[{k_q, 3'b000} +: 8] <= mem_rdata_i;
            if (!last_byte) k_q <= k_q + KW'(1);
        end
    end

    assign mem_rd_o   = (state_q == S_READ);
    assign mem_addr_o = pc_q + WAD'(k_q);
    assign valid_o    = (state_q == S_RESP);
    assign instrF     = instr_q;
    assign stall_o    = req_i && !(valid_o && accept_i);

endmodule

// File: tb/tb_ifetch_seq.sv
// tb/tb_ifetch_seq.sv - self-checking bench for ifetch_seq with a byte memory responder
module tb_ifetch_seq;

    localparam int WAD = 17;
    localparam int DW  = 32;
    localparam int MEM_SIZE = 1 << WAD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_i;
    logic [DW-1:0] pcF;
    logic          flush_i;
    logic          accept_i;
    logic [DW-1:0] instrF;
    logic          valid_o;
    logic          stall_o;
    logic [WAD-1:0] mem_addr_o;
    logic          mem_rd_o;
    logic [7:0]    mem_rdata_i;
    logic          mem_rvalid_i;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic          misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]     mem [0:MEM_SIZE-1];
    logic [WAD-1:0] rd_q [$];
    logic [WAD-1:0] pend_addr [$];
    int             pend_cnt [$];
    int             lat_min = 1;
    int             lat_max = 1;

    ifetch_seq #(.WAD(WAD), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .pcF          (pcF),
        .flush_i      (flush_i),
        .accept_i     (accept_i),
        .instrF       (instrF),
        .valid_o      (valid_o),
        .stall_o      (stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder: every read returns one byte after a random latency, in order.
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 8'h00;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
            if (pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem[pend_addr[0]];
                void'(pend_cnt.pop_front());
                void'(pend_addr.pop_front());
            end
            if (mem_rd_o === 1'b1) begin
                rd_q.push_back(mem_addr_o);
                pend_addr.push_back(mem_addr_o);
                pend_cnt.push_back(int'($urandom_range(lat_max, lat_min)));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: an instruction is the four bytes from its address upward, little-endian, wrapping at 2**WAD.
    function automatic logic [DW-1:0] model_instr(input logic [DW-1:0] a);
        logic [DW-1:0] r;
        int unsigned   base;
        r = '0;
        base = a % MEM_SIZE;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mem[(base + i) % MEM_SIZE];
        return r;
    endfunction

    function automatic logic [WAD-1:0] model_addr(input logic [DW-1:0] a, input int i);
        return WAD'((a % MEM_SIZE + i) % MEM_SIZE);
    endfunction

    function automatic bit addr_seq_ok(input logic [DW-1:0] a);
        if (rd_q.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (rd_q[i] !== model_addr(a, i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_valid(output logic [DW-1:0] ins, output int cyc, output int first_rd,
                              output int stall_bad, output bit tmo);
        cyc = 0; first_rd = -1; stall_bad = 0; tmo = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_rd_o === 1'b1 && first_rd < 0) first_rd = cyc;
            if (stall_o !== 1'b1) stall_bad++;
            if (valid_o === 1'b1) break;
            if (cyc >= 200) begin tmo = 1'b1; break; end
        end
        ins = instrF;
    endtask

    task automatic fetch_once(input logic [DW-1:0] a, output logic [DW-1:0] ins, output int cyc,
                              output int first_rd, output int stall_bad, output bit tmo);
        rd_q.delete();
        req_i = 1'b1;
        pcF   = a;
        wait_valid(ins, cyc, first_rd, stall_bad, tmo);
    endtask

    task automatic accept_now();
        accept_i = 1'b1;
        req_i    = 1'b0;
        @(negedge clk);
        accept_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        total++; if (mem_rd_o !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b expected 0", mem_rd_o); end
        total++; if (mem_addr_o !== '0) begin bad++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
        total++; if (instrF !== '0) begin bad++; $display("FAIL reset_instr: got %h expected 0", instrF); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
`ifdef IFETCH_MISALIGN_CHK_EN
        total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
`endif
    endtask

    task automatic test_basic();
        logic [DW-1:0] ins; int cyc, first_rd, sb; bit tmo;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        lat_min = 1; lat_max = 1;
        fetch_once(32'h0, ins, cyc, first_rd, sb, tmo);
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout: got timeout expected valid_o"); end
        total++; if (ins !== 32'h00100513) begin bad++; $display("FAIL basic_instr: got %h expected 00100513", ins); end
        total++; if (first_rd !== 1) begin bad++; $display("FAIL basic_first_rd: got cycle %0d expected 1", first_rd); end
        total++; if (cyc - first_rd !== 8) begin bad++; $display("FAIL basic_latency: got %0d expected 8", cyc - first_rd); end
        total++; if (sb !== 0) begin bad++; $display("FAIL basic_stall: got %0d low cycles expected 0", sb); end
        total++; if (!addr_seq_ok(32'h0)) begin bad++; $display("FAIL basic_addrs: got %0d reads expected 0..3", rd_q.size()); end
        accept_i = 1'b1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL basic_stall_accept: got %b expected 0", stall_o); end
        req_i = 1'b0;
        @(negedge clk);
        accept_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL basic_after_accept: got %b expected 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ins; int cyc, first_rd, sb; bit tmo;
        for (int i = 4; i < 8; i++) mem[i] = 8'($urandom);
        lat_min = 1; lat_max = 2;
        fetch_once(32'h0, ins, cyc, first_rd, sb, tmo);
        total++; if (ins !== model_instr(32'h0)) begin bad++; $display("FAIL b2b_first: got %h expected %h", ins, model_instr(32'h0)); end
        accept_i = 1'b1; req_i = 1'b1; pcF = 32'h4;
        rd_q.delete();
        @(negedge clk);
        accept_i = 1'b0;
        total++; if (mem_rd_o !== 1'b1) begin bad++; $display("FAIL b2b_rd: got %b expected 1", mem_rd_o); end
        total++; if (mem_addr_o !== WAD'(4)) begin bad++; $display("FAIL b2b_addr: got %h expected 4", mem_addr_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_valid: got %b expected 0", valid_o); end
        wait_valid(ins, cyc, first_rd, sb, tmo);
        total++; if (tmo) begin bad++; $display("FAIL b2b_timeout: got timeout expected valid_o"); end
        total++; if (ins !== model_instr(32'h4)) begin bad++; $display("FAIL b2b_second: got %h expected %h", ins, model_instr(32'h4)); end
        total++; if (!addr_seq_ok(32'h4)) begin bad++; $display("FAIL b2b_addrs: got %0d reads expected 4..7", rd_q.size()); end
        accept_now();
    endtask

    task automatic test_flush();
        logic [DW-1:0] ins; int cyc, first_rd, sb; bit tmo;
        int rds = 0; int c = 0;
        mem[32'h20] = 8'hA5; mem[32'h21] = 8'h5A; mem[32'h22] = 8'hC3; mem[32'h23] = 8'h3C;
        lat_min = 3; lat_max = 3;
        req_i = 1'b1; pcF = 32'h0;
        while (rds < 3 && c < 100) begin
            @(negedge clk); c++;
            if (mem_rd_o === 1'b1) rds++;
        end
        total++; if (rds !== 3) begin bad++; $display("FAIL flush_setup: got %0d reads expected 3", rds); end
        @(negedge clk);
        flush_i = 1'b1; pcF = 32'h20;
        rd_q.delete();
        @(negedge clk);
        flush_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
        total++; if (mem_rd_o !== 1'b0) begin bad++; $display("FAIL flush_rd: got %b expected 0", mem_rd_o); end
        lat_min = 1; lat_max = 2;
        wait_valid(ins, cyc, first_rd, sb, tmo);
        total++; if (tmo) begin bad++; $display("FAIL flush_timeout: got timeout expected valid_o"); end
        total++; if (ins !== model_instr(32'h20)) begin bad++; $display("FAIL flush_refetch: got %h expected %h", ins, model_instr(32'h20)); end
        total++; if (!addr_seq_ok(32'h20)) begin bad++; $display("FAIL flush_addrs: got %0d reads expected 20..23", rd_q.size()); end
        accept_now();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] ins; int cyc, first_rd, sb; bit tmo;
        logic [DW-1:0] a;
        a = MEM_SIZE - 2;
        lat_min = 1; lat_max = 3;
        fetch_once(a, ins, cyc, first_rd, sb, tmo);
        total++; if (!(rd_q.size() == 4 && rd_q[0] == 17'h1FFFE && rd_q[1] == 17'h1FFFF &&
                       rd_q[2] == 17'h00000 && rd_q[3] == 17'h00001)) begin
            bad++; $display("FAIL wrap_addrs: got %0d reads expected 1FFFE,1FFFF,0,1", rd_q.size());
        end
        total++; if (ins !== model_instr(a)) begin bad++; $display("FAIL wrap_instr: got %h expected %h", ins, model_instr(a)); end
        accept_now();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ins; int cyc, first_rd, sb; bit tmo;
        int rds = 0; int c = 0;
        lat_min = 1; lat_max = 1;
        req_i = 1'b1; pcF = 32'h0;
        while (rds < 2 && c < 100) begin
            @(negedge clk); c++;
            if (mem_rd_o === 1'b1) rds++;
        end
        total++; if (rds !== 2) begin bad++; $display("FAIL rstmid_setup: got %0d reads expected 2", rds); end
        rst_n = 1'b0; req_i = 1'b0;
        #1;
        total++; if ({valid_o, mem_rd_o, stall_o} !== 3'b000) begin
            bad++; $display("FAIL rstmid_flags: got %b expected 000", {valid_o, mem_rd_o, stall_o});
        end
        total++; if (mem_addr_o !== '0) begin bad++; $display("FAIL rstmid_addr: got %h expected 0", mem_addr_o); end
        total++; if (instrF !== '0) begin bad++; $display("FAIL rstmid_instr: got %h expected 0", instrF); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_once(32'h0, ins, cyc, first_rd, sb, tmo);
        total++; if (ins !== model_instr(32'h0)) begin bad++; $display("FAIL rstmid_refetch: got %h expected %h", ins, model_instr(32'h0)); end
        total++; if (!addr_seq_ok(32'h0)) begin bad++; $display("FAIL rstmid_addrs: got %0d reads expected 0..3", rd_q.size()); end
        accept_now();
    endtask

    task automatic test_random();
        logic [DW-1:0] ins; int cyc, first_rd, sb; bit tmo;
        logic [DW-1:0] a;
        int   hold;
        bit   hold_ok;
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
`ifdef IFETCH_MISALIGN_CHK_EN
            a[1:0] = 2'b00;
`endif
            fetch_once(a, ins, cyc, first_rd, sb, tmo);
            total++; if (tmo) begin bad++; $display("FAIL rand_timeout[%0d]: got timeout expected valid_o", n); end
            total++; if (ins !== model_instr(a)) begin bad++; $display("FAIL rand_instr[%0d]: got %h expected %h", n, ins, model_instr(a)); end
            total++; if (!addr_seq_ok(a)) begin bad++; $display("FAIL rand_addrs[%0d]: got %0d reads expected 4 from %h", n, rd_q.size(), model_addr(a, 0)); end
            hold = int'($urandom_range(3, 0));
            hold_ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (valid_o !== 1'b1 || instrF !== ins) hold_ok = 1'b0;
            end
            total++; if (!hold_ok) begin bad++; $display("FAIL rand_hold[%0d]: got unstable RESP expected stable %h", n, ins); end
            accept_now();
        end
    endtask

`ifdef IFETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        bit mis_ok = 1'b1;
        bit rd_seen = 1'b0;
        req_i = 1'b1; pcF = 32'h6;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (misalign_o !== 1'b1) mis_ok = 1'b0;
            @(negedge clk);
            if (mem_rd_o !== 1'b0) rd_seen = 1'b1;
        end
        total++; if (!mis_ok) begin bad++; $display("FAIL misalign_flag: got low expected 1"); end
        total++; if (rd_seen) begin bad++; $display("FAIL misalign_rd: got read expected none"); end
        req_i = 1'b0;
        #1;
        total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL misalign_clear: got %b expected 0", misalign_o); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0; req_i = 1'b0; pcF = '0; flush_i = 1'b0; accept_i = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef IFETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_seq.md
IFETCH_SEQ -- requirements
Module: ifetch_seq

Interface
REQ-001 SHALL have parameter WAD, default 17, meaning byte-address width of the instruction memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning pc and instruction width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_i  input  1  fetch stage requests an instruction at pcF.
REQ-006 SHALL have port pcF  input  DATA_WIDTH  byte address of the requested instruction.
REQ-007 SHALL have port flush_i  input  1  abort the current fetch (branch/jump redirect).
REQ-008 SHALL have port accept_i  input  1  fetch stage consumes instrF this cycle.
REQ-009 SHALL have port instrF  output  DATA_WIDTH  assembled little-endian instruction.
REQ-010 SHALL have port valid_o  output  1  instrF holds a complete instruction.
REQ-011 SHALL have port stall_o  output  1  fetch stage must hold pcF.
REQ-012 SHALL have port mem_addr_o  output  WAD  byte address to instruction memory.
REQ-013 SHALL have port mem_rd_o  output  1  byte read request, single outstanding.
REQ-014 SHALL have port mem_rdata_i  input  8  returned byte.
REQ-015 SHALL have port mem_rvalid_i  input  1  mem_rdata_i valid, one pulse per read, latency >= 1 cycle.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, RESP, DRAIN.
REQ-017 SHALL, in IDLE with req_i=1 and flush_i=0, latch pcF, clear byte counter k, go to READ.
REQ-018 SHALL, in READ, assert mem_rd_o for exactly one cycle with mem_addr_o = (latched pc + k) truncated to WAD bits (wrap-around at 2**WAD), then go to WAIT.
REQ-019 SHALL, in WAIT on mem_rvalid_i, store mem_rdata_i into instrF[8k+7:8k]; go to READ with k+1 if k<3, else to RESP.
REQ-020 SHALL hold valid_o=1 and instrF stable throughout RESP; on accept_i go to READ for a new fetch if req_i=1 (latching pcF that cycle), else IDLE.
REQ-021 SHALL give minimum latency of 8 cycles from req_i to valid_o with 1-cycle memory latency.
REQ-022 SHALL drive stall_o = req_i AND NOT (valid_o AND accept_i).
REQ-023 SHALL, on flush_i in READ or RESP, go to IDLE, dropping partial or complete data; in WAIT go to DRAIN.
REQ-024 SHALL, in DRAIN, discard the next mem_rvalid_i beat and then go to IDLE; a flush_i in DRAIN keeps DRAIN.
REQ-025 SHALL give flush_i priority over accept_i and mem_rvalid_i in the same cycle; valid_o is 0 in the cycle after a flush.
REQ-026 SHALL ignore mem_rvalid_i in IDLE, READ and RESP.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously enter IDLE with instrF=0, valid_o=0, mem_rd_o=0, mem_addr_o=0, k=0, misalign_o=0.
REQ-028 SHALL, on reset mid-fetch, abandon any outstanding read with no drain; the memory-side beat after reset release is ignored per REQ-026.

Configuration
REQ-029 SHALL, with IFETCH_MISALIGN_CHK_EN defined, add output misalign_o (1 bit) and refuse requests with pcF[1:0]!=0: stay in IDLE, no memory read, misalign_o=1 while such a request is present.
REQ-030 SHALL, without IFETCH_MISALIGN_CHK_EN, omit misalign_o and fetch any byte address, misaligned included.

Structure
REQ-031 SHALL place the FSM state enum and the constant BYTES_PER_INSTR=4 in shared package ifetch_pkg.
REQ-032 SHALL be a single module with no sub-modules; the existing combinational instruction memory connects through a byte-wide wrapper outside this block.

Verification
REQ-033 SHALL cover: bytes 0x13,0x05,0x10,0x00 at addr 0x0, req_i with pcF=0 -> instrF=0x00100513, valid_o on cycle 8, stall_o high until accept.
REQ-034 SHALL cover: back-to-back req_i with pcF=0 then 4, accept_i on the first valid -> second fetch issues mem_rd_o with mem_addr_o=4 the next cycle.
REQ-035 SHALL cover: flush_i during WAIT of byte 2 -> one beat discarded, no valid_o, next req_i with pcF=0x20 fetches the bytes at 0x20.
REQ-036 SHALL cover: pcF=2**WAD-2 -> mem_addr_o sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-037 SHALL cover: rst_n low during READ of byte 1 -> all outputs 0 immediately, clean fetch of pcF=0 after release.
REQ-038 SHALL cover, with IFETCH_MISALIGN_CHK_EN: pcF=0x6 -> misalign_o=1, mem_rd_o stays 0.
